// File: rtl/rgbled_seq.sv
// Frame sequencer for a WS281x LED chain: double-buffered colour table streamed
// word-by-word into the serialiser, followed by a latch gap between frames.
module rgbled_seq #(
   parameter int unsigned NumLeds     = 2,
   parameter int unsigned ResetCycles = 1500,
   parameter int unsigned IdxW        = (NumLeds > 1) ? $clog2(NumLeds) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            cfg_we_i,
   input  logic [IdxW-1:0] cfg_idx_i,
   input  logic [23:0]     cfg_data_i,
   input  logic            update_i,
   input  logic            blank_i,
   output logic            busy_o,
   output logic            frame_done_o,
   output logic            drv_go_o,
   output logic [23:0]     drv_data_o,
   output logic            drv_data_valid_o,
   output logic            drv_data_last_o,
   input  logic            drv_data_ack_i,
   input  logic            drv_idle_i
);

   // Tables are sized to the full index range so any idx value is a legal
   // array select; entries at or above NumLeds are never written.
   localparam int unsigned Depth = 1 << IdxW;
   localparam int unsigned GapW  = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StSend     = 2'd1;
   localparam logic [1:0] StWaitIdle = 2'd2;
   localparam logic [1:0] StGap      = 2'd3;

   logic [1:0]      state;
   logic [IdxW-1:0] idx;
   logic [GapW-1:0] gap_cnt;
   logic            pending;
   logic [23:0]     stage_buf  [Depth];
   logic [23:0]     active_buf [Depth];

   logic cfg_hit;
   logic start;
   logic word_last;
   logic in_send;

   function automatic logic [23:0] to_grb(input logic [23:0] rgb);
      return {rgb[15:8], rgb[23:16], rgb[7:0]};
   endfunction

   assign cfg_hit   = cfg_we_i && (32'(cfg_idx_i) < NumLeds);
   assign start     = (state == StIdle) && (pending || update_i);
   assign word_last = (32'(idx) == NumLeds - 1);
   assign in_send   = (state == StSend);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) stage_buf[i] <= '0;
      end else if (cfg_hit) begin
         stage_buf[cfg_idx_i] <= cfg_data_i;
      end
   end

   // A write landing in the same cycle as the snapshot is forwarded into it.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) active_buf[i] <= '0;
      end else if (start) begin
         for (int i = 0; i < Depth; i++) begin
            active_buf[i] <= (cfg_hit && (cfg_idx_i == IdxW'(i))) ? cfg_data_i : stage_buf[i];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= StIdle;
         idx     <= '0;
         gap_cnt <= '0;
         pending <= 1'b0;
      end else begin
         // The request that launches a frame is consumed; later ones coalesce.
         if (start)         pending <= 1'b0;
         else if (update_i) pending <= 1'b1;

         case (state)
            StIdle: begin
               if (start) begin
                  state <= StSend;
                  idx   <= '0;
               end
            end
            StSend: begin
               if (drv_data_ack_i) begin
                  if (word_last) begin
                     state <= StWaitIdle;
                     idx   <= '0;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            StWaitIdle: begin
               if (drv_idle_i) begin
                  state   <= StGap;
                  gap_cnt <= GapW'(ResetCycles - 1);
               end
            end
            StGap: begin
               if (gap_cnt == '0) state <= StIdle;
               else               gap_cnt <= gap_cnt - 1'b1;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign busy_o           = (state != StIdle);
   assign frame_done_o     = (state == StGap) && (gap_cnt == '0);
   assign drv_go_o         = in_send;
   assign drv_data_valid_o = in_send;
   assign drv_data_last_o  = in_send && word_last;
   assign drv_data_o       = (in_send && !blank_i) ? to_grb(active_buf[idx]) : 24'h000000;

endmodule

// File: tb/tb_rgbled_seq.sv
// Directed bench for rgbled_seq: a 2-LED instance with a short gap and a 1-LED instance.
module tb_rgbled_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        we, upd, blank, ack, idle;
   logic [1:0]  cidx;
   logic [23:0] cdata;
   logic        busy, fd, go, vld, last;
   logic [23:0] data;

   logic        we1, upd1, ack1, idle1;
   logic [0:0]  cidx1;
   logic [23:0] cdata1;
   logic        busy1, fd1, go1, vld1, last1;
   logic [23:0] data1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rgbled_seq #(.NumLeds(2), .ResetCycles(4), .IdxW(2)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we), .cfg_idx_i(cidx), .cfg_data_i(cdata),
      .update_i(upd), .blank_i(blank), .busy_o(busy), .frame_done_o(fd), .drv_go_o(go),
      .drv_data_o(data), .drv_data_valid_o(vld), .drv_data_last_o(last),
      .drv_data_ack_i(ack), .drv_idle_i(idle)
   );

   rgbled_seq #(.NumLeds(1), .ResetCycles(1)) u_one (
      .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(we1), .cfg_idx_i(cidx1), .cfg_data_i(cdata1),
      .update_i(upd1), .blank_i(blank), .busy_o(busy1), .frame_done_o(fd1), .drv_go_o(go1),
      .drv_data_o(data1), .drv_data_valid_o(vld1), .drv_data_last_o(last1),
      .drv_data_ack_i(ack1), .drv_idle_i(idle1)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic word(input string tag, input logic [23:0] exp_data, input logic exp_last);
      chk1({tag, "_valid"}, vld, 1'b1);
      chk1({tag, "_go"}, go, 1'b1);
      chk24({tag, "_data"}, data, exp_data);
      chk1({tag, "_last"}, last, exp_last);
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      cyc();
      ack = 1'b0;
   endtask

   // Called in WAIT_IDLE; ends on the cycle IDLE is re-entered.
   task automatic drain(input string tag);
      idle = 1'b1;
      cyc();
      idle = 1'b0;
      chk1({tag, "_gap3_fd"}, fd, 1'b0);
      chk1({tag, "_gap_busy"}, busy, 1'b1);
      cyc();
      cyc();
      chk1({tag, "_gap1_fd"}, fd, 1'b0);
      cyc();
      chk1({tag, "_gap0_fd"}, fd, 1'b1);
      cyc();
      chk1({tag, "_idle_fd"}, fd, 1'b0);
      chk1({tag, "_idle_busy"}, busy, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; we = 1'b0; upd = 1'b1; blank = 1'b0; ack = 1'b0; idle = 1'b0;
      cidx = 2'd0; cdata = 24'h0;
      we1 = 1'b0; upd1 = 1'b0; ack1 = 1'b0; idle1 = 1'b0; cidx1 = 1'b0; cdata1 = 24'h0;

      // reset held with update asserted
      cyc(); cyc(); cyc();
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_go", go, 1'b0);
      chk1("rst_valid", vld, 1'b0);
      chk1("rst_last", last, 1'b0);
      chk1("rst_fd", fd, 1'b0);
      chk24("rst_data", data, 24'h000000);
      rst_n = 1'b1;
      cyc();
      upd = 1'b0;
      chk1("rel_busy", busy, 1'b1);
      word("rel_w0", 24'h000000, 1'b0);
      ack_pulse();
      word("rel_w1", 24'h000000, 1'b1);
      ack_pulse();
      chk1("rel_wait_valid", vld, 1'b0);
      drain("rel");
      cyc();
      chk1("rel_stay_idle", busy, 1'b0);

      // normal frame
      we = 1'b1; cidx = 2'd0; cdata = 24'h112233;
      cyc();
      cidx = 2'd1; cdata = 24'h445566;
      cyc();
      we = 1'b0; upd = 1'b1;
      cyc();
      upd = 1'b0;
      word("nf_w0", 24'h221133, 1'b0);
      cyc();
      word("nf_w0_hold", 24'h221133, 1'b0);
      ack_pulse();
      word("nf_w1", 24'h554466, 1'b1);
      cyc();
      word("nf_w1_hold", 24'h554466, 1'b1);
      ack_pulse();
      chk1("nf_wait_valid", vld, 1'b0);
      chk1("nf_wait_go", go, 1'b0);
      chk1("nf_wait_last", last, 1'b0);
      chk24("nf_wait_data", data, 24'h000000);
      ack_pulse();
      chk1("nf_stray_ack_busy", busy, 1'b1);
      chk1("nf_stray_ack_valid", vld, 1'b0);
      drain("nf");

      // write and double update during SEND
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      word("ws_w0", 24'h221133, 1'b0);
      we = 1'b1; cidx = 2'd0; cdata = 24'hFF0000; upd = 1'b1;
      cyc();
      we = 1'b0; upd = 1'b0;
      word("ws_w0_old", 24'h221133, 1'b0);
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      ack_pulse();
      word("ws_w1", 24'h554466, 1'b1);
      ack_pulse();
      drain("ws");
      cyc();
      word("ws2_w0", 24'h00FF00, 1'b0);
      ack_pulse();
      word("ws2_w1", 24'h554466, 1'b1);
      ack_pulse();
      drain("ws2");
      cyc();
      chk1("ws_no_third_busy", busy, 1'b0);
      cyc();
      chk1("ws_no_third_valid", vld, 1'b0);

      // blank, released mid-frame
      blank = 1'b1; upd = 1'b1;
      cyc();
      upd = 1'b0;
      word("bl_w0", 24'h000000, 1'b0);
      ack_pulse();
      word("bl_w1", 24'h000000, 1'b1);
      blank = 1'b0;
      #1;
      word("bl_w1_unblank", 24'h554466, 1'b1);
      ack_pulse();
      drain("bl");

      // out-of-range writes, then write bypass into the snapshot
      we = 1'b1; cidx = 2'd2; cdata = 24'h123456;
      cyc();
      cidx = 2'd3; cdata = 24'h654321;
      cyc();
      cidx = 2'd1; cdata = 24'hABCDEF; upd = 1'b1;
      cyc();
      we = 1'b0; upd = 1'b0;
      word("ew_w0", 24'h00FF00, 1'b0);
      ack_pulse();
      word("ew_w1", 24'hCDABEF, 1'b1);
      ack_pulse();
      drain("ew");

      // reset mid-frame with an update queued
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      word("rm_w0", 24'h00FF00, 1'b0);
      ack = 1'b1; upd = 1'b1;
      cyc();
      ack = 1'b0; upd = 1'b0;
      rst_n = 1'b0;
      cyc();
      chk1("rm_busy", busy, 1'b0);
      chk1("rm_valid", vld, 1'b0);
      chk1("rm_go", go, 1'b0);
      chk24("rm_data", data, 24'h000000);
      rst_n = 1'b1;
      cyc();
      cyc();
      chk1("rm_no_frame_busy", busy, 1'b0);
      chk1("rm_no_frame_valid", vld, 1'b0);
      upd = 1'b1;
      cyc();
      upd = 1'b0;
      word("rm_w0_cleared", 24'h000000, 1'b0);
      ack_pulse();
      word("rm_w1_cleared", 24'h000000, 1'b1);
      ack_pulse();
      drain("rm");

      // single-LED chain with write bypass on the starting update
      we1 = 1'b1; cidx1 = 1'b0; cdata1 = 24'h0A0B0C; upd1 = 1'b1;
      cyc();
      we1 = 1'b0; upd1 = 1'b0;
      chk1("one_valid", vld1, 1'b1);
      chk1("one_go", go1, 1'b1);
      chk1("one_last", last1, 1'b1);
      chk24("one_data", data1, 24'h0B0A0C);
      ack1 = 1'b1;
      cyc();
      ack1 = 1'b0;
      chk1("one_wait_valid", vld1, 1'b0);
      chk1("one_wait_busy", busy1, 1'b1);
      idle1 = 1'b1;
      cyc();
      idle1 = 1'b0;
      chk1("one_fd", fd1, 1'b1);
      cyc();
      chk1("one_idle_busy", busy1, 1'b0);
      chk1("one_idle_fd", fd1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
